// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard, two read ports, one issue and one write-back port.
// Latency: reads are combinational; write data, pending bits, pend_cnt and wb_err update at the next rising edge.
// Backpressure: none; every issue and write-back is accepted in the cycle it is presented.
module regfile_sb #(
    parameter int DATA_W     = 4,
    parameter int NUM_REGS   = 16,
    parameter int ZERO_REG   = 1,
    parameter int RESET_MODE = 1,
    parameter int BYPASS     = 1,
    localparam int ADDR_W    = $clog2(NUM_REGS),
    localparam int CNT_W     = $clog2(NUM_REGS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_pend1,
    output logic              rd_pend2,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  pend_cnt,
    output logic              wb_err
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                wr_ok, iss_ok;

    // Qualify strobes: the hardwired zero register swallows writes and issues.
    always_comb begin
        wr_ok  = wr_en  && !(ZR && (wr_addr  == '0));
        iss_ok = iss_en && !(ZR && (iss_addr == '0));
    end

    // Next scoreboard state: clear on write-back, then set on issue so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[iss_addr] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + CNT_W'(pend_d[i]);
        end
        err_d = err_q | (wr_ok & ~pend_q[wr_addr]);
    end

    // Register storage; reset image is either all zeros or each register's own index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= (RESET_MODE != 0) ? DATA_W'(i) : '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Scoreboard bits, their population count and the sticky spurious write-back flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Read port 1: zero register, then same-cycle forwarding, then storage.
    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_pend1 = pend_q[rd_addr1];
        if (ZR && (rd_addr1 == '0)) begin
            rd_data1 = '0;
            rd_pend1 = 1'b0;
        end else if (BP && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_pend1 = 1'b0;
        end
    end

    // Read port 2: identical priority to port 1 so both agree on a shared address.
    always_comb begin
        rd_data2 = mem_q[rd_addr2];
        rd_pend2 = pend_q[rd_addr2];
        if (ZR && (rd_addr2 == '0)) begin
            rd_data2 = '0;
            rd_pend2 = 1'b0;
        end else if (BP && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_pend2 = 1'b0;
        end
    end

    assign pend_cnt = cnt_q;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: vector table for the main sequence plus hand-written reset/fill sequences.
// A second instance without forwarding shares the stimulus to contrast same-cycle read behaviour.
module tb_regfile_sb;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] rd_addr1, rd_addr2, iss_addr, wr_addr, wr_data;
    logic       iss_en, wr_en;
    logic [3:0] rd_data1, rd_data2;
    logic       rd_pend1, rd_pend2;
    logic [4:0] pend_cnt;
    logic       wb_err;
    logic [3:0] nb_d1, nb_d2;
    logic       nb_p1, nb_p2;
    logic [4:0] nb_cnt;
    logic       nb_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_sb dut (
        .clock(clock), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_cnt(pend_cnt), .wb_err(wb_err)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_d1), .rd_data2(nb_d2),
        .rd_pend1(nb_p1), .rd_pend2(nb_p2),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_cnt(nb_cnt), .wb_err(nb_err)
    );

    typedef struct {
        logic       ie;
        logic [3:0] ia;
        logic       we;
        logic [3:0] wa;
        logic [3:0] wd;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] d1;
        logic       p1;
        logic [3:0] d2;
        logic       p2;
        logic [3:0] nb1;
        logic [4:0] cnt;
        logic       err;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic ie, input logic [3:0] ia, input logic we,
                                input logic [3:0] wa, input logic [3:0] wd,
                                input logic [3:0] ra1, input logic [3:0] ra2,
                                input logic [3:0] d1, input logic p1,
                                input logic [3:0] d2, input logic p2,
                                input logic [3:0] nb1, input logic [4:0] cnt, input logic err);
        vec_t v;
        v.ie = ie; v.ia = ia; v.we = we; v.wa = wa; v.wd = wd;
        v.ra1 = ra1; v.ra2 = ra2; v.d1 = d1; v.p1 = p1; v.d2 = d2; v.p2 = p2;
        v.nb1 = nb1; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_en = 1'b0; iss_addr = '0;
        wr_en  = 1'b0; wr_addr  = '0; wr_data = '0;
    endtask

    initial begin
        //             ie ia     we wa     wd      ra1    ra2    d1     p1 d2     p2 nb1    cnt err
        tbl[0]  = mk(1, 4'd5, 0, 4'd0, 4'h0, 4'd5, 4'd3, 4'h5, 0, 4'h3, 0, 4'h5, 5'd1, 0);
        tbl[1]  = mk(0, 4'd0, 1, 4'd5, 4'hA, 4'd5, 4'd5, 4'hA, 0, 4'hA, 0, 4'h5, 5'd0, 0);
        tbl[2]  = mk(0, 4'd0, 0, 4'd0, 4'h0, 4'd5, 4'd3, 4'hA, 0, 4'h3, 0, 4'hA, 5'd0, 0);
        tbl[3]  = mk(1, 4'd3, 0, 4'd0, 4'h0, 4'd3, 4'd7, 4'h3, 0, 4'h7, 0, 4'h3, 5'd1, 0);
        tbl[4]  = mk(1, 4'd7, 0, 4'd0, 4'h0, 4'd3, 4'd7, 4'h3, 1, 4'h7, 0, 4'h3, 5'd2, 0);
        tbl[5]  = mk(0, 4'd0, 1, 4'd3, 4'hC, 4'd3, 4'd7, 4'hC, 0, 4'h7, 1, 4'h3, 5'd1, 0);
        tbl[6]  = mk(0, 4'd0, 0, 4'd0, 4'h0, 4'd3, 4'd7, 4'hC, 0, 4'h7, 1, 4'hC, 5'd1, 0);
        tbl[7]  = mk(1, 4'd4, 0, 4'd0, 4'h0, 4'd4, 4'd4, 4'h4, 0, 4'h4, 0, 4'h4, 5'd2, 0);
        tbl[8]  = mk(1, 4'd4, 1, 4'd4, 4'h6, 4'd4, 4'd7, 4'h6, 0, 4'h7, 1, 4'h4, 5'd2, 0);
        tbl[9]  = mk(0, 4'd0, 0, 4'd0, 4'h0, 4'd4, 4'd7, 4'h6, 1, 4'h7, 1, 4'h6, 5'd2, 0);
        tbl[10] = mk(1, 4'd0, 1, 4'd0, 4'hF, 4'd0, 4'd0, 4'h0, 0, 4'h0, 0, 4'h0, 5'd2, 0);
        tbl[11] = mk(1, 4'd8, 1, 4'd7, 4'h1, 4'd7, 4'd8, 4'h1, 0, 4'h8, 0, 4'h7, 5'd2, 0);
        tbl[12] = mk(0, 4'd0, 1, 4'd9, 4'h2, 4'd9, 4'd8, 4'h2, 0, 4'h8, 1, 4'h9, 5'd2, 1);
        tbl[13] = mk(0, 4'd0, 1, 4'd4, 4'hB, 4'd9, 4'd4, 4'h2, 0, 4'hB, 0, 4'h2, 5'd1, 1);
        tbl[14] = mk(0, 4'd0, 0, 4'd0, 4'h0, 4'd4, 4'd8, 4'hB, 0, 4'h8, 1, 4'hB, 5'd1, 1);

        // Reset image: register i holds i, nothing pending.
        reset = 1'b1;
        idle_inputs();
        rd_addr1 = '0; rd_addr2 = '0;
        #12;
        reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = 4'(a);
            rd_addr2 = 4'(15 - a);
            #1;
            chk($sformatf("rst_d1[%0d]", a), 32'(rd_data1), 32'(a));
            chk($sformatf("rst_d2[%0d]", 15 - a), 32'(rd_data2), 32'(15 - a));
            if (rd_pend1 !== 1'b0 || rd_pend2 !== 1'b0) begin
                chk($sformatf("rst_pend[%0d]", a), 32'({rd_pend1, rd_pend2}), 32'd0);
            end
        end
        chk("rst_cnt", 32'(pend_cnt), 32'd0);
        chk("rst_err", 32'(wb_err), 32'd0);

        @(posedge clock); #1;

        // Main vector sequence: comb outputs before the edge, registered outputs after it.
        for (int i = 0; i < 15; i++) begin
            iss_en = tbl[i].ie; iss_addr = tbl[i].ia;
            wr_en  = tbl[i].we; wr_addr  = tbl[i].wa; wr_data = tbl[i].wd;
            rd_addr1 = tbl[i].ra1; rd_addr2 = tbl[i].ra2;
            #1;
            chk($sformatf("v%0d_d1", i), 32'(rd_data1), 32'(tbl[i].d1));
            chk($sformatf("v%0d_p1", i), 32'(rd_pend1), 32'(tbl[i].p1));
            chk($sformatf("v%0d_d2", i), 32'(rd_data2), 32'(tbl[i].d2));
            chk($sformatf("v%0d_p2", i), 32'(rd_pend2), 32'(tbl[i].p2));
            chk($sformatf("v%0d_nb1", i), 32'(nb_d1), 32'(tbl[i].nb1));
            @(posedge clock); #1;
            chk($sformatf("v%0d_cnt", i), 32'(pend_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_err", i), 32'(wb_err), 32'(tbl[i].err));
        end
        idle_inputs();

        // Issue every non-zero register; r8 is already pending so it is a WAW re-issue.
        for (int a = 1; a < 16; a++) begin
            iss_en = 1'b1; iss_addr = 4'(a);
            @(posedge clock); #1;
        end
        idle_inputs();
        rd_addr1 = 4'd15; rd_addr2 = 4'd0;
        #1;
        chk("fill_cnt", 32'(pend_cnt), 32'd15);
        chk("fill_p15", 32'(rd_pend1), 32'd1);
        chk("fill_p0", 32'(rd_pend2), 32'd0);

        // First write-back of the re-issued r8 clears it.
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 4'hD;
        @(posedge clock); #1;
        idle_inputs();
        rd_addr1 = 4'd8;
        #1;
        chk("waw_cnt", 32'(pend_cnt), 32'd14);
        chk("waw_p8", 32'(rd_pend1), 32'd0);
        chk("waw_d8", 32'(rd_data1), 32'hD);
        chk("waw_err_sticky", 32'(wb_err), 32'd1);

        // Reset asserted between edges with an issue and write in flight.
        iss_en = 1'b1; iss_addr = 4'd8;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'h0;
        rd_addr1 = 4'd8; rd_addr2 = 4'd9;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cnt", 32'(pend_cnt), 32'd0);
        chk("arst_err", 32'(wb_err), 32'd0);
        chk("arst_p8", 32'(rd_pend1), 32'd0);
        chk("arst_d8", 32'(rd_data1), 32'd8);
        chk("arst_d9", 32'(rd_data2), 32'd9);
        @(posedge clock);
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        rd_addr1 = 4'd5;
        #1;
        chk("post_rst_cnt", 32'(pend_cnt), 32'd0);
        chk("post_rst_d5", 32'(rd_data1), 32'd5);
        @(posedge clock); #1;
        chk("post_rst_cnt2", 32'(pend_cnt), 32'd0);
        chk("post_rst_err2", 32'(wb_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
